// File: rtl/vec3_result_buf.sv
// Credit-reserved result FIFO at the tail of a fixed-latency, non-stallable vec3 pipeline.
// Define PATHSY_VEC3_BUF_ERR_EN to drop overflow pushes and raise a sticky err flag.
module vec3_result_buf #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        issue_rdy,
    input  logic        issue_vld,
    input  logic        result_vld,
    input  logic [95:0] result,
    output logic        out_vld,
    output logic [95:0] out,
    input  logic        out_rdy,
    output logic        err
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [95:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] reserved;
    logic             push;
    logic             pop;
    logic             issue;

    assign issue_rdy = (reserved < CNT_W'(DEPTH));
    assign issue     = issue_vld & issue_rdy;
    assign out_vld   = (count != '0);
    assign out       = mem[rd_ptr];
    assign pop       = out_vld & out_rdy;

`ifdef PATHSY_VEC3_BUF_ERR_EN
    logic overflow;

    // A pop in the same cycle frees the slot, so only a push into a full, stalled FIFO overflows.
    assign overflow = result_vld && (count == CNT_W'(DEPTH)) && !pop;
    assign push     = result_vld & ~overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (overflow) begin
            err <= 1'b1;
        end
    end
`else
    assign push = result_vld;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            reserved <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            reserved <= reserved + CNT_W'(issue) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_vec3_result_buf.sv
// Directed bench for vec3_result_buf: queue-based reference model checked every cycle,
// plus literal expectations at the points of interest.
module tb_vec3_result_buf;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_rdy;
    logic        issue_vld = 1'b0;
    logic        result_vld = 1'b0;
    logic [95:0] result = '0;
    logic        out_vld;
    logic [95:0] out;
    logic        out_rdy = 1'b0;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [95:0] q[$];
    int          res_m   = 0;
    bit          err_m   = 1'b0;
    bit          started = 1'b0;

    vec3_result_buf #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_rdy  (issue_rdy),
        .issue_vld  (issue_vld),
        .result_vld (result_vld),
        .result     (result),
        .out_vld    (out_vld),
        .out        (out),
        .out_rdy    (out_rdy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] vec_a(input int i);
        return {32'(i), 32'(i + 100), 32'(i + 200)};
    endfunction

    function automatic logic [95:0] vec_b(input int i);
        return {32'(i + 1000), 32'(i + 2000), 32'(i + 3000)};
    endfunction

    // Reference model: FIFO as a queue, credits as a plain integer.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            res_m   = 0;
            err_m   = 1'b0;
            started = 1'b1;
        end else begin
            bit pop_m;
            bit full_m;
            bit iss_m;
            pop_m  = (q.size() != 0) && out_rdy;
            full_m = (q.size() == DEPTH);
            iss_m  = issue_vld && (res_m < DEPTH);
            if (pop_m) void'(q.pop_front());
            if (result_vld) begin
                if (full_m && !pop_m) begin
`ifdef PATHSY_VEC3_BUF_ERR_EN
                    err_m = 1'b1;
`endif
                end else begin
                    q.push_back(result);
                end
            end
            res_m = res_m + int'(iss_m) - int'(pop_m);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("issue_rdy", 96'(issue_rdy), 96'(res_m < DEPTH));
            chk("out_vld", 96'(out_vld), 96'(q.size() != 0));
            chk("err", 96'(err), 96'(err_m));
            if (q.size() != 0) chk("out", out, q[0]);
        end
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset out_vld", 96'(out_vld), 96'(0));
        chk("reset issue_rdy", 96'(issue_rdy), 96'(1));
        chk("reset err", 96'(err), 96'(0));

        // Single result through an empty FIFO with downstream ready.
        issue_vld = 1'b1;
        tick();
        issue_vld  = 1'b0;
        result_vld = 1'b1;
        result     = {32'h3F800000, 32'h40000000, 32'h40400000};
        out_rdy    = 1'b1;
        tick();
        result_vld = 1'b0;
        chk("one out_vld", 96'(out_vld), 96'(1));
        chk("one out", out, {32'h3F800000, 32'h40000000, 32'h40400000});
        tick();
        chk("one drained", 96'(out_vld), 96'(0));
        out_rdy = 1'b0;

        // Reserve all credits, then deliver results.
        issue_vld = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        chk("credits exhausted", 96'(issue_rdy), 96'(0));
        tick();
        chk("ignored issue", 96'(issue_rdy), 96'(0));
        issue_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            result_vld = 1'b1;
            result     = vec_a(i);
            tick();
            if (i == 0) chk("first push out", out, vec_a(0));
        end
        result_vld = 1'b0;
        chk("full out_vld", 96'(out_vld), 96'(1));
        chk("full head", out, vec_a(0));

        // Issue while out of credits, alongside a pop.
        issue_vld = 1'b1;
        out_rdy   = 1'b1;
        #1;
        chk("issue at reserved=8", 96'(issue_rdy), 96'(0));
        tick();
        issue_vld = 1'b0;
        out_rdy   = 1'b0;

        // Refill to full, then stream through the full FIFO across pointer wrap.
        issue_vld = 1'b1;
        tick();
        issue_vld  = 1'b0;
        result_vld = 1'b1;
        result     = vec_a(8);
        tick();
        issue_vld = 1'b1;
        out_rdy   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            result = vec_b(i);
            tick();
        end
        result_vld = 1'b0;
        issue_vld  = 1'b0;
        chk("stream err", 96'(err), 96'(0));
        chk("stream head", out, vec_b(8));

        // Drain three, leaving five held, then reset.
        tick();
        tick();
        tick();
        out_rdy = 1'b0;
        chk("five held head", out, vec_b(11));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid reset out_vld", 96'(out_vld), 96'(0));
        chk("mid reset issue_rdy", 96'(issue_rdy), 96'(1));
        chk("mid reset err", 96'(err), 96'(0));

        // Late result from a pre-reset op is stored like any other.
        result_vld = 1'b1;
        result     = vec_a(42);
        tick();
        result_vld = 1'b0;
        chk("late result", out, vec_a(42));
        rst = 1'b1;
        tick();
        rst = 1'b0;

`ifdef PATHSY_VEC3_BUF_ERR_EN
        issue_vld = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        issue_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            result_vld = 1'b1;
            result     = vec_a(i + 50);
            tick();
        end
        result = vec_b(99);
        tick();
        result_vld = 1'b0;
        chk("overflow err", 96'(err), 96'(1));
        chk("overflow head", out, vec_a(50));
        out_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("overflow order", out, vec_a(i + 50));
            tick();
        end
        out_rdy = 1'b0;
        chk("overflow empty", 96'(out_vld), 96'(0));
        chk("err sticky", 96'(err), 96'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err cleared", 96'(err), 96'(0));
`endif

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
